// File: rtl/tnoc_axi_burst_sequencer.sv
// Splits one NoC request into legal AXI AR/AW bursts. Each burst is clipped to the
// data-bus beat size, to the 256-beat limit and to the current 4KB page.
//
// state | meaning
// IDLE  | ready for a request; latches address, clipped size and beat count
// LOAD  | computes the first burst and registers it onto the AX outputs
// ISSUE | presents bursts; after each handshake either loads the next burst or finishes
module tnoc_axi_burst_sequencer #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int BYTE_LENGTH_WIDTH = 13,
  parameter int DATA_WIDTH        = 256,
  parameter int ID_WIDTH          = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]     i_req_address,
  input  logic [BYTE_LENGTH_WIDTH-1:0] i_req_length,
  input  logic [2:0]                   i_req_size,
  input  logic [ID_WIDTH-1:0]          i_req_id,
  output logic                         o_ax_valid,
  input  logic                         i_ax_ready,
  output logic [ADDRESS_WIDTH-1:0]     o_ax_addr,
  output logic [7:0]                   o_ax_len,
  output logic [2:0]                   o_ax_size,
  output logic [1:0]                   o_ax_burst,
  output logic [ID_WIDTH-1:0]          o_ax_id,
  output logic                         o_ax_last,
  output logic                         o_busy
);
  localparam int MAX_SIZE    = $clog2(DATA_WIDTH / 8);
  localparam int BEATS_WIDTH = BYTE_LENGTH_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  state_t                   state;
  logic [BEATS_WIDTH-1:0]   beats_q;
  logic [ADDRESS_WIDTH-1:0] cur_addr_q;
  logic [8:0]               n_q;

  logic [2:0]               req_size;
  logic [6:0]               req_mask;
  logic [BEATS_WIDTH-1:0]   req_beats;
  logic [BEATS_WIDTH-1:0]   next_beats;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [8:0]               load_n;
  logic [8:0]               next_n;

  // Beats in the burst starting at page_off: limited by what is left, by 256 and by the page end.
  function automatic logic [8:0] burst_beats(input logic [BEATS_WIDTH-1:0] beats,
                                             input logic [11:0] page_off,
                                             input logic [2:0] size);
    logic [12:0] page_room;
    logic [8:0]  n;
    page_room = (13'd4096 - {1'b0, page_off}) >> size;
    n = (beats > BEATS_WIDTH'(256)) ? 9'd256 : beats[8:0];
    if (page_room < 13'(n)) n = page_room[8:0];
    return n;
  endfunction

  // A 7-bit mask covers every size code; 1<<7 wraps to 0 so the mask becomes 127.
  assign req_size  = (i_req_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : i_req_size;
  assign req_mask  = (7'd1 << req_size) - 7'd1;
  assign req_beats = (BEATS_WIDTH'(i_req_address[6:0] & req_mask) + BEATS_WIDTH'(i_req_length)
                      + BEATS_WIDTH'(req_mask)) >> req_size;

  assign next_beats = beats_q - BEATS_WIDTH'(n_q);
  assign next_addr  = cur_addr_q + (ADDRESS_WIDTH'(n_q) << o_ax_size);
  assign load_n     = burst_beats(beats_q, cur_addr_q[11:0], o_ax_size);
  assign next_n     = burst_beats(next_beats, next_addr[11:0], o_ax_size);

  assign o_ax_burst = 2'b01;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_ax_valid  <= 1'b0;
      o_ax_addr   <= '0;
      o_ax_len    <= '0;
      o_ax_size   <= '0;
      o_ax_id     <= '0;
      o_ax_last   <= 1'b0;
      o_busy      <= 1'b0;
      beats_q     <= '0;
      cur_addr_q  <= '0;
      n_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_ax_size   <= req_size;
            o_ax_id     <= i_req_id;
            beats_q     <= req_beats;
            cur_addr_q  <= i_req_address & ~ADDRESS_WIDTH'(req_mask);
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          o_ax_valid <= 1'b1;
          o_ax_addr  <= cur_addr_q;
          o_ax_len   <= 8'(load_n - 9'd1);
          o_ax_last  <= (BEATS_WIDTH'(load_n) == beats_q);
          n_q        <= load_n;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (i_ax_ready) begin
            beats_q    <= next_beats;
            cur_addr_q <= next_addr;
            if (o_ax_last) begin
              o_ax_valid  <= 1'b0;
              o_req_ready <= 1'b1;
              o_busy      <= 1'b0;
              state       <= IDLE;
            end else begin
              o_ax_addr <= next_addr;
              o_ax_len  <= 8'(next_n - 9'd1);
              o_ax_last <= (BEATS_WIDTH'(next_n) == next_beats);
              n_q       <= next_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A zero-length request has no defined split.
  zero_length_request: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_req_valid && o_req_ready) |-> (i_req_length != '0));

endmodule

// File: tb/tb_tnoc_axi_burst_sequencer.sv
// Bench for tnoc_axi_burst_sequencer: directed cases plus random requests, each
// compared burst by burst against a byte-arithmetic model of the split.
module tb_tnoc_axi_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_address = '0;
  logic [12:0] req_length = '0;
  logic [2:0]  req_size = '0;
  logic [3:0]  req_id = '0;
  logic        ax_valid;
  logic        ax_ready = 1'b0;
  logic [63:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic [3:0]  ax_id;
  logic        ax_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned addr;
    int              len;
    bit              last;
  } burst_t;

  tnoc_axi_burst_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_address(req_address), .i_req_length(req_length),
    .i_req_size(req_size), .i_req_id(req_id),
    .o_ax_valid(ax_valid), .i_ax_ready(ax_ready),
    .o_ax_addr(ax_addr), .o_ax_len(ax_len), .o_ax_size(ax_size),
    .o_ax_burst(ax_burst), .o_ax_id(ax_id), .o_ax_last(ax_last),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and checks every burst. stall_burst gets stall_cycles of ready=0,
  // other bursts a random 0..2; abort_burst (>=0) asserts reset while that burst is presented.
  task automatic run_req(input logic [63:0] addr, input int len, input int size,
                         input logic [3:0] id, input int stall_burst, input int stall_cycles,
                         input int abort_burst);
    burst_t          exp_q[$];
    burst_t          e;
    int              sz_c;
    int              k;
    longint unsigned bb, a, total, room, n;

    // Model: round start down to the beat, count beats covering the bytes, then cut greedily.
    sz_c  = (size > 5) ? 5 : size;
    bb    = 64'd1 << sz_c;
    a     = addr - (addr % bb);
    total = ((addr % bb) + longint'(len) + bb - 1) / bb;
    while (total > 0) begin
      room = (4096 - (a % 4096)) / bb;
      n = total;
      if (n > 256) n = 256;
      if (n > room) n = room;
      e.addr = a;
      e.len  = int'(n) - 1;
      e.last = (n == total);
      exp_q.push_back(e);
      a     = a + n * bb;
      total = total - n;
    end

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_address = addr;
    req_length  = 13'(len);
    req_size    = 3'(size);
    req_id      = id;
    @(negedge clk);
    req_valid   = 1'b0;
    req_address = {$urandom, $urandom};
    req_length  = 13'($urandom_range(1, 8191));
    req_size    = 3'($urandom_range(0, 7));
    req_id      = 4'($urandom_range(0, 15));
    check("load_busy", 64'(busy), 64'd1);
    check("load_req_ready", 64'(req_ready), 64'd0);
    check("load_ax_valid", 64'(ax_valid), 64'd0);
    @(negedge clk);

    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check("ax_valid", 64'(ax_valid), 64'd1);
      check("ax_addr", ax_addr, e.addr);
      check("ax_len", 64'(ax_len), 64'(e.len));
      check("ax_size", 64'(ax_size), 64'(sz_c));
      check("ax_id", 64'(ax_id), 64'(id));
      check("ax_last", 64'(ax_last), 64'(e.last));
      check("ax_burst", 64'(ax_burst), 64'd1);
      check("issue_req_ready", 64'(req_ready), 64'd0);
      if (i == abort_burst) begin
        #1 rst = 1'b1;
        #1;
        check("abort_valid", 64'(ax_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("no_residual_valid", 64'(ax_valid), 64'd0);
        end
        return;
      end
      k = (i == stall_burst) ? stall_cycles : $urandom_range(0, 2);
      repeat (k) begin
        ax_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", 64'(ax_valid), 64'd1);
        check("hold_addr", ax_addr, e.addr);
        check("hold_len", 64'(ax_len), 64'(e.len));
        check("hold_last", 64'(ax_last), 64'(e.last));
        check("hold_req_ready", 64'(req_ready), 64'd0);
      end
      ax_ready = 1'b1;
      @(negedge clk);
      ax_ready = 1'b0;
    end
    check("done_valid", 64'(ax_valid), 64'd0);
    check("done_req_ready", 64'(req_ready), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_ax_valid", 64'(ax_valid), 64'd0);
    check("rst_ax_addr", ax_addr, 64'd0);
    check("rst_ax_len", 64'(ax_len), 64'd0);
    check("rst_ax_size", 64'(ax_size), 64'd0);
    check("rst_ax_id", 64'(ax_id), 64'd0);
    check("rst_ax_last", 64'(ax_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req(64'h103, 8, 2, 4'h3, -1, 0, -1);
    run_req(64'hFF0, 32, 2, 4'h5, -1, 0, -1);
    run_req(64'h0, 2048, 2, 4'h7, 0, 0, -1);
    run_req(64'h40, 64, 7, 4'h9, -1, 0, -1);
    run_req(64'h0, 2048, 2, 4'hA, 1, 5, -1);
    run_req(64'hFFFF_FFFF_FFFF_FFF0, 64, 4, 4'hB, -1, 0, -1);
    run_req(64'h0, 3000, 2, 4'hC, -1, 0, 1);
    run_req(64'h0, 3000, 2, 4'hD, -1, 0, -1);
    run_req(64'h1234_5000, 8191, 0, 4'hE, -1, 0, -1);

    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 63));
      run_req(ra, $urandom_range(1, 8191), $urandom_range(0, 7), 4'($urandom_range(0, 15)),
              -1, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
